mem_port_arbiter: RTL and testbench

- Arbitrates the single shared memory port between the instruction fetch path (IFU / icache refill) and the MEM-stage load/store path (LSU).
- Supports one outstanding transaction at a time.
- LSU has fixed priority, with a starvation guard for IFU.
- Pipeline redirects (flush) cancel delivery of an in-flight IFU response.
- Sits between the pipeline front/back ends and the memory/bus bridge.

---
 rtl/mem_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//    Shares the single memory port between the instruction fetch path (IFU)
//    and the load/store path (LSU). Only one transaction is outstanding at a
//    time. The LSU has fixed priority, but a streak counter forces one IFU
//    grant through after MAX_STREAK back-to-back LSU grants that left the IFU
//    waiting. A pipeline flush cancels delivery of an in-flight fetch
//    response, but the memory side still completes normally.
//
// Ports
//    clock, reset                 clock, synchronous active-high reset
//    ifu_req/ifu_addr             fetch request and address
//    ifu_gnt/ifu_rvalid/ifu_rdata fetch accept pulse, response pulse and data
//    lsu_req/we/addr/wdata/wstrb  load/store request and payload
//    lsu_gnt/lsu_rvalid/lsu_rdata accept pulse, response pulse, load data
//    flush                        pipeline redirect, kills fetch delivery
//    mem_req/we/addr/wdata/wstrb  memory request, held until mem_ready
//    mem_ready                    memory accepts the request this cycle
//    mem_rvalid/mem_rdata         memory response (read data or write ack)
//    busy                         high whenever a transaction is in progress
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_STREAK = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ifu_req,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_gnt,
   output logic                ifu_rvalid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_req,
   input  logic                lsu_we,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   output logic                lsu_gnt,
   output logic                lsu_rvalid,
   output logic [DATA_W-1:0]   lsu_rdata,
   input  logic                flush,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(MAX_STREAK + 1);
   localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_STREAK);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t              state_r;
   logic                owner_lsu_r;   // 1 = LSU owns the transaction, 0 = IFU
   logic                drop_r;        // fetch response must not be delivered
   logic [CNT_W-1:0]    streak_r;      // LSU grants in a row while IFU waited
   logic                mem_req_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [DATA_W-1:0]   mem_wdata_r;
   logic [STRB_W-1:0]   mem_wstrb_r;
   logic                ifu_rvalid_r;
   logic [DATA_W-1:0]   ifu_rdata_r;
   logic                lsu_rvalid_r;
   logic [DATA_W-1:0]   lsu_rdata_r;

   logic                ifu_elig_s;
   logic                pick_ifu_s;
   logic                pick_lsu_s;

   // A fetch that arrives together with a redirect is already stale.
   assign ifu_elig_s = ifu_req & ~flush;

   // Arbitration in IDLE; grants are same-cycle pulses, so this is combinational.
   always_comb begin
      pick_ifu_s = 1'b0;
      pick_lsu_s = 1'b0;
      if ((state_r == ST_IDLE) && !reset) begin
         if (lsu_req && ifu_elig_s) begin
            if (streak_r == STREAK_MAX) begin
               pick_ifu_s = 1'b1;
            end else begin
               pick_lsu_s = 1'b1;
            end
         end else if (lsu_req) begin
            pick_lsu_s = 1'b1;
         end else if (ifu_elig_s) begin
            pick_ifu_s = 1'b1;
         end else begin
            pick_ifu_s = 1'b0;
            pick_lsu_s = 1'b0;
         end
      end else begin
         pick_ifu_s = 1'b0;
         pick_lsu_s = 1'b0;
      end
   end

   // Transaction FSM with payload, response and streak registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         owner_lsu_r  <= 1'b0;
         drop_r       <= 1'b0;
         streak_r     <= {CNT_W{1'b0}};
         mem_req_r    <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_wdata_r  <= {DATA_W{1'b0}};
         mem_wstrb_r  <= {STRB_W{1'b0}};
         ifu_rvalid_r <= 1'b0;
         ifu_rdata_r  <= {DATA_W{1'b0}};
         lsu_rvalid_r <= 1'b0;
         lsu_rdata_r  <= {DATA_W{1'b0}};
      end else begin
         // Response pulses last exactly one cycle.
         ifu_rvalid_r <= 1'b0;
         lsu_rvalid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               drop_r <= 1'b0;
               if (pick_lsu_s) begin
                  owner_lsu_r <= 1'b1;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= lsu_we;
                  mem_addr_r  <= lsu_addr;
                  mem_wdata_r <= lsu_wdata;
                  // Reads never carry strobes.
                  mem_wstrb_r <= lsu_we ? lsu_wstrb : {STRB_W{1'b0}};
                  // Only grants that made the IFU wait count toward the streak.
                  if (ifu_req) begin
                     streak_r <= (streak_r == STREAK_MAX) ? streak_r
                                                          : streak_r + CNT_W'(1);
                  end else begin
                     streak_r <= {CNT_W{1'b0}};
                  end
                  state_r <= ST_REQ;
               end else if (pick_ifu_s) begin
                  owner_lsu_r <= 1'b0;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= 1'b0;
                  mem_addr_r  <= ifu_addr;
                  mem_wdata_r <= {DATA_W{1'b0}};
                  mem_wstrb_r <= {STRB_W{1'b0}};
                  streak_r    <= {CNT_W{1'b0}};
                  state_r     <= ST_REQ;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REQ: begin
               // A response arriving before acceptance is spurious and ignored.
               if (!owner_lsu_r && flush) begin
                  drop_r <= 1'b1;
               end
               if (mem_ready) begin
                  mem_req_r <= 1'b0;
                  state_r   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  state_r <= ST_IDLE;
                  drop_r  <= 1'b0;
                  if (owner_lsu_r) begin
                     lsu_rvalid_r <= 1'b1;
                     lsu_rdata_r  <= mem_we_r ? {DATA_W{1'b0}} : mem_rdata;
                  end else if (!drop_r && !flush) begin
                     // A redirect in the response cycle also kills delivery.
                     ifu_rvalid_r <= 1'b1;
                     ifu_rdata_r  <= mem_rdata;
                  end
               end else if (!owner_lsu_r && flush) begin
                  drop_r <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               mem_req_r <= 1'b0;
               drop_r    <= 1'b0;
            end
         endcase
      end
   end

   assign ifu_gnt    = pick_ifu_s;
   assign lsu_gnt    = pick_lsu_s;
   assign ifu_rvalid = ifu_rvalid_r;
   assign ifu_rdata  = ifu_rdata_r;
   assign lsu_rvalid = lsu_rvalid_r;
   assign lsu_rdata  = lsu_rdata_r;
   assign mem_req    = mem_req_r;
   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign mem_wdata  = mem_wdata_r;
   assign mem_wstrb  = mem_wstrb_r;
   assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//    Table of per-cycle {inputs, expected outputs} records for reset, single
//    fetch, simultaneous requests, flush and store; hand-written sequences
//    for the starvation pattern and reset in the middle of a transaction.
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_gnt;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic        lsu_req;
   logic        lsu_we;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wstrb;
   logic        lsu_gnt;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        flush;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
      .clock(clock), .reset(reset),
      .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
      .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_gnt(lsu_gnt),
      .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      logic        lreq;
      logic        lwe;
      logic [31:0] laddr;
      logic [31:0] lwdata;
      logic [3:0]  lstrb;
      logic        fl;
      logic        mrdy;
      logic        mrv;
      logic [31:0] mrdata;
   } in_t;

   typedef struct packed {
      logic        ignt;
      logic        lgnt;
      logic        irv;
      logic        lrv;
      logic [31:0] irdata;
      logic [31:0] lrdata;
      logic        mreq;
      logic        mwe;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [3:0]  mstrb;
      logic        bsy;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   vec_t vecs[$];
   in_t  a;
   out_t e;
   int   gq[$];

   task automatic drive(input in_t v);
      reset      = v.rst;
      ifu_req    = v.ireq;
      ifu_addr   = v.iaddr;
      lsu_req    = v.lreq;
      lsu_we     = v.lwe;
      lsu_addr   = v.laddr;
      lsu_wdata  = v.lwdata;
      lsu_wstrb  = v.lstrb;
      flush      = v.fl;
      mem_ready  = v.mrdy;
      mem_rvalid = v.mrv;
      mem_rdata  = v.mrdata;
   endtask

   // Response data is only defined while its valid pulses and write data only
   // for stores, so those fields are masked unless mask is 0.
   task automatic check_out(input out_t exp, input bit mask, input string nm);
      out_t act;
      out_t want;
      act.ignt   = ifu_gnt;
      act.lgnt   = lsu_gnt;
      act.irv    = ifu_rvalid;
      act.lrv    = lsu_rvalid;
      act.irdata = ifu_rdata;
      act.lrdata = lsu_rdata;
      act.mreq   = mem_req;
      act.mwe    = mem_we;
      act.maddr  = mem_addr;
      act.mwdata = mem_wdata;
      act.mstrb  = mem_wstrb;
      act.bsy    = busy;
      want = exp;
      if (mask) begin
         if (!exp.irv) begin
            act.irdata  = 32'h0;
            want.irdata = 32'h0;
         end
         if (!exp.lrv) begin
            act.lrdata  = 32'h0;
            want.lrdata = 32'h0;
         end
         if (!exp.mwe) begin
            act.mwdata  = 32'h0;
            want.mwdata = 32'h0;
         end
      end
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic clr_pulses();
      e.ignt = 1'b0;
      e.lgnt = 1'b0;
      e.irv  = 1'b0;
      e.lrv  = 1'b0;
   endtask

   task automatic push();
      vec_t v;
      v.i = a;
      v.o = e;
      vecs.push_back(v);
   endtask

   initial begin
      a = '0;
      e = '0;
      // reset, including a request that must not be granted during reset
      a = '0; a.rst = 1'b1; e = '0; push();
      a = '0; a.rst = 1'b1; a.ireq = 1'b1; a.iaddr = 32'h0000_0100; push();
      // single fetch: gnt N, mem_req N+1, rvalid N+4
      a = '0; a.ireq = 1'b1; a.iaddr = 32'h0000_0100; clr_pulses(); e.ignt = 1'b1; push();
      a = '0; a.mrdy = 1'b1; clr_pulses(); e.mreq = 1'b1; e.maddr = 32'h0000_0100;
      e.mwe = 1'b0; e.mstrb = 4'h0; e.bsy = 1'b1; push();
      a = '0; clr_pulses(); e.mreq = 1'b0; push();
      a = '0; a.mrv = 1'b1; a.mrdata = 32'h0010_0093; clr_pulses(); push();
      a = '0; clr_pulses(); e.irv = 1'b1; e.irdata = 32'h0010_0093; e.bsy = 1'b0; push();
      // simultaneous: LSU load first, IFU granted as lsu_rvalid pulses
      a = '0; a.ireq = 1'b1; a.iaddr = 32'h0000_0200; a.lreq = 1'b1;
      a.laddr = 32'h8000_0004; a.lstrb = 4'hF; clr_pulses(); e.lgnt = 1'b1; push();
      a = '0; a.ireq = 1'b1; a.iaddr = 32'h0000_0200; a.mrdy = 1'b1; clr_pulses();
      e.mreq = 1'b1; e.maddr = 32'h8000_0004; e.mwe = 1'b0; e.mstrb = 4'h0; e.bsy = 1'b1; push();
      a = '0; a.ireq = 1'b1; a.iaddr = 32'h0000_0200; a.mrv = 1'b1; a.mrdata = 32'h1234_5678;
      clr_pulses(); e.mreq = 1'b0; push();
      a = '0; a.ireq = 1'b1; a.iaddr = 32'h0000_0200; clr_pulses(); e.lrv = 1'b1;
      e.lrdata = 32'h1234_5678; e.ignt = 1'b1; e.bsy = 1'b0; push();
      // IFU fetch at 0x200, flushed while waiting for data
      a = '0; clr_pulses(); e.mreq = 1'b1; e.maddr = 32'h0000_0200; e.bsy = 1'b1; push();
      a = '0; a.mrdy = 1'b1; clr_pulses(); push();
      a = '0; a.fl = 1'b1; clr_pulses(); e.mreq = 1'b0; push();
      a = '0; a.mrv = 1'b1; a.mrdata = 32'hAAAA_5555; clr_pulses(); push();
      // dropped response, and a fetch coincident with flush is not granted
      a = '0; a.ireq = 1'b1; a.iaddr = 32'h0000_0240; a.fl = 1'b1; clr_pulses(); e.bsy = 1'b0; push();
      a = '0; a.ireq = 1'b1; a.iaddr = 32'h0000_0300; clr_pulses(); e.ignt = 1'b1; push();
      a = '0; a.mrdy = 1'b1; clr_pulses(); e.mreq = 1'b1; e.maddr = 32'h0000_0300; e.bsy = 1'b1; push();
      a = '0; a.mrv = 1'b1; a.mrdata = 32'h0000_0013; clr_pulses(); e.mreq = 1'b0; push();
      a = '0; clr_pulses(); e.irv = 1'b1; e.irdata = 32'h0000_0013; e.bsy = 1'b0; push();
      // store with 3 stall cycles; stray rvalid in REQ and flush are ignored
      a = '0; a.lreq = 1'b1; a.lwe = 1'b1; a.laddr = 32'h8000_0010;
      a.lwdata = 32'hDEAD_BEEF; a.lstrb = 4'b0011; clr_pulses(); e.lgnt = 1'b1; push();
      a = '0; clr_pulses(); e.mreq = 1'b1; e.maddr = 32'h8000_0010; e.mwe = 1'b1;
      e.mwdata = 32'hDEAD_BEEF; e.mstrb = 4'b0011; e.bsy = 1'b1; push();
      a = '0; a.mrv = 1'b1; a.mrdata = 32'h1111_1111; clr_pulses(); push();
      a = '0; a.fl = 1'b1; clr_pulses(); push();
      a = '0; a.mrdy = 1'b1; clr_pulses(); push();
      a = '0; a.mrv = 1'b1; a.mrdata = 32'hFFFF_FFFF; a.fl = 1'b1; clr_pulses(); e.mreq = 1'b0; push();
      a = '0; clr_pulses(); e.lrv = 1'b1; e.lrdata = 32'h0; e.bsy = 1'b0; push();

      a = '0;
      drive(a);
      @(posedge clock);
      #1;
      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k].i);
         @(negedge clock);
         check_out(vecs[k].o, 1'b1, $sformatf("vec%0d", k));
         @(posedge clock);
         #1;
      end

      // starvation: both held high, memory answers immediately
      a = '0; a.ireq = 1'b1; a.iaddr = 32'h0000_0400; a.lreq = 1'b1;
      a.laddr = 32'h8000_0100; a.mrdy = 1'b1; a.mrv = 1'b1; a.mrdata = 32'h5A5A_5A5A;
      drive(a);
      for (int c = 0; c < 45; c++) begin
         @(negedge clock);
         total++;
         if ((ifu_gnt && lsu_gnt) || (ifu_rvalid && lsu_rvalid)) begin
            bad++;
            $display("FAIL excl_c%0d: gnt %b%b rvalid %b%b, want at most one each",
                     c, ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid);
         end
         if (lsu_gnt) gq.push_back(1);
         if (ifu_gnt) gq.push_back(2);
         @(posedge clock);
         #1;
      end
      total++;
      if (gq.size() != 15) begin
         bad++;
         $display("FAIL starve_count: got %0d grants want 15", gq.size());
      end
      for (int k = 0; k < 15; k++) begin
         if (k < gq.size()) begin
            total++;
            if (gq[k] != ((k % 5 == 4) ? 2 : 1)) begin
               bad++;
               $display("FAIL starve_g%0d: got %0d want %0d (1=lsu 2=ifu)",
                        k, gq[k], (k % 5 == 4) ? 2 : 1);
            end
         end
      end

      // reset during WAIT, then stray responses after reset
      a = '0; a.ireq = 1'b1; a.iaddr = 32'h0000_0500;
      drive(a);
      @(negedge clock);
      total++;
      if (ifu_gnt !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_gnt: got gnt=%b busy=%b want gnt=1 busy=0", ifu_gnt, busy);
      end
      @(posedge clock);
      #1;
      a = '0; a.mrdy = 1'b1;
      drive(a);
      @(posedge clock);
      #1;
      a = '0; a.rst = 1'b1;
      drive(a);
      @(negedge clock);
      total++;
      if (busy !== 1'b1 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL rst_wait: got busy=%b mem_req=%b want busy=1 mem_req=0", busy, mem_req);
      end
      @(posedge clock);
      #1;
      for (int c = 0; c < 3; c++) begin
         a = '0; a.mrv = (c < 2) ? 1'b1 : 1'b0; a.mrdata = 32'hBAD0_BAD0;
         drive(a);
         @(negedge clock);
         check_out('0, 1'b0, $sformatf("rst_after%0d", c));
         @(posedge clock);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
